ejecutor_corte: RTL and testbench

Cutter-head executor for the cutting controller's playback interface. It consumes the target coordinate the controller presents on its x/y outputs while `cortando` is high, and drives two step/direction axis pairs toward that point one unit per step tick. When the point is reached and settled, it returns a one-cycle `dato_siguiente` pulse that tells the controller to fetch the next stored point. It sits between the controller top level and the motor drivers, and is the consumer end of the controller's point-playback handshake.

---
 rtl/ejecutor_corte_pkg.sv | 23 ++
 rtl/eje_paso.sv | 62 ++++++
 rtl/ejecutor_corte.sv | 154 +++++++++++++++
 tb/tb_ejecutor_corte.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ejecutor_corte_pkg.sv
// Shared definitions for the cutter-head executor: state encodings, default
// parameter values and the counter-width helper.
package ejecutor_corte_pkg;

  typedef enum logic [2:0] {
    REPOSO  = 3'd0,
    CARGAR  = 3'd1,
    MOVER   = 3'd2,
    ASENTAR = 3'd3,
    PEDIR   = 3'd4
  } estado_t;

  localparam int BITS_EJE_DEF            = 6;
  localparam int DIVISOR_PASO_DEF        = 4;
  localparam int LATENCIA_DATO_DEF       = 2;
  localparam int CICLOS_ASENTAMIENTO_DEF = 3;

  // Width of a counter running 0..n-1; never narrower than one bit.
  function automatic int ancho_cnt(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/eje_paso.sv
// Single axis: target and position registers, comparator and step/dir
// generator. A tick moves the position one unit toward the target.
module eje_paso
  import ejecutor_corte_pkg::*;
#(
  parameter int bits_eje = BITS_EJE_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tick,
  input  logic                cargar,
  input  logic [bits_eje-1:0] objetivo,
  output logic [bits_eje-1:0] actual,
  output logic                paso,
  output logic                dir,
  output logic                en_objetivo
);

  logic [bits_eje-1:0] r_actual;
  logic [bits_eje-1:0] r_objetivo;
  logic                r_paso;
  logic                r_dir;

  logic w_igual;
  logic w_mayor;
  logic w_dir;
  logic w_avanza;

  assign w_igual  = (r_actual == r_objetivo);
  assign w_mayor  = (r_objetivo > r_actual);
  assign w_avanza = tick && !w_igual;

  // The position has already stepped when paso is visible, so on the final
  // step the comparison reads "equal"; hold the last direction instead.
  assign w_dir = w_igual ? r_dir : w_mayor;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_actual   <= '0;
      r_objetivo <= '0;
      r_paso     <= 1'b0;
      r_dir      <= 1'b0;
    end else begin
      r_paso <= w_avanza;
      r_dir  <= w_dir;
      if (cargar) begin
        r_objetivo <= objetivo;
      end
      if (w_avanza) begin
        r_actual <= w_mayor ? r_actual + bits_eje'(1) : r_actual - bits_eje'(1);
      end
    end
  end

  assign actual      = r_actual;
  assign paso        = r_paso;
  assign dir         = w_dir;
  assign en_objetivo = w_igual;

endmodule

// File: rtl/ejecutor_corte.sv
// Cutter-head executor: fetches a target point from the controller, steps
// both axes toward it, settles, then requests the next point.
module ejecutor_corte
  import ejecutor_corte_pkg::*;
#(
  parameter int bits_eje            = BITS_EJE_DEF,
  parameter int divisor_paso        = DIVISOR_PASO_DEF,
  parameter int latencia_dato       = LATENCIA_DATO_DEF,
  parameter int ciclos_asentamiento = CICLOS_ASENTAMIENTO_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cortando,
  input  logic [bits_eje-1:0] x_objetivo,
  input  logic [bits_eje-1:0] y_objetivo,
  output logic                dato_siguiente,
  output logic [bits_eje-1:0] x_actual,
  output logic [bits_eje-1:0] y_actual,
  output logic                paso_x,
  output logic                paso_y,
  output logic                dir_x,
  output logic                dir_y,
  output logic                en_movimiento,
  output logic [2:0]          estado
);

  localparam int W_PRE = ancho_cnt(divisor_paso);
  localparam int W_LAT = ancho_cnt(latencia_dato);
  localparam int W_ASE = ancho_cnt(ciclos_asentamiento);

  localparam logic [W_PRE-1:0] PRE_ULT  = W_PRE'(divisor_paso - 1);
  localparam logic [W_PRE-1:0] PRE_TICK = W_PRE'(divisor_paso - 2);
  localparam logic [W_LAT-1:0] LAT_ULT  = W_LAT'(latencia_dato - 1);
  localparam logic [W_ASE-1:0] ASE_ULT  = W_ASE'(ciclos_asentamiento - 1);

  estado_t          r_estado;
  estado_t          w_siguiente;
  logic [W_PRE-1:0] r_pre;
  logic [W_LAT-1:0] r_lat;
  logic [W_ASE-1:0] r_ase;
  logic             r_dato;
  logic             r_en_mov;

  logic w_tick;
  logic w_cargar;
  logic w_en_x;
  logic w_en_y;

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave a value held and infer a latch.
  always_comb begin
    w_siguiente = r_estado;
    w_tick      = 1'b0;
    w_cargar    = 1'b0;
    case (r_estado)
      REPOSO: begin
        if (cortando) w_siguiente = CARGAR;
      end
      CARGAR: begin
        if (!cortando) begin
          w_siguiente = REPOSO;
        end else if (r_lat == LAT_ULT) begin
          w_cargar    = 1'b1;
          w_siguiente = MOVER;
        end
      end
      MOVER: begin
        if (!cortando) begin
          w_siguiente = REPOSO;
        end else if (w_en_x && w_en_y) begin
          w_siguiente = ASENTAR;
        end else begin
          // Fire one cycle early so paso is visible in the divisor_paso-th cycle.
          w_tick = (r_pre == PRE_TICK);
        end
      end
      ASENTAR: begin
        if (!cortando) begin
          w_siguiente = REPOSO;
        end else if (r_ase == ASE_ULT) begin
          w_siguiente = PEDIR;
        end
      end
      PEDIR: begin
        w_siguiente = cortando ? CARGAR : REPOSO;
      end
      default: begin
        w_siguiente = REPOSO;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_estado <= REPOSO;
    end else begin
      r_estado <= w_siguiente;
    end
  end

  // Counters run only while their state persists and clear on every exit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pre    <= '0;
      r_lat    <= '0;
      r_ase    <= '0;
      r_dato   <= 1'b0;
      r_en_mov <= 1'b0;
    end else begin
      if (r_estado == MOVER && w_siguiente == MOVER) begin
        r_pre <= (r_pre == PRE_ULT) ? '0 : r_pre + W_PRE'(1);
      end else begin
        r_pre <= '0;
      end
      r_lat    <= (r_estado == CARGAR && w_siguiente == CARGAR) ? r_lat + W_LAT'(1) : '0;
      r_ase    <= (r_estado == ASENTAR && w_siguiente == ASENTAR) ? r_ase + W_ASE'(1) : '0;
      r_dato   <= (w_siguiente == PEDIR);
      r_en_mov <= (w_siguiente == MOVER);
    end
  end

  eje_paso #(
    .bits_eje (bits_eje)
  ) u_eje_x (
    .clock       (clock),
    .reset       (reset),
    .tick        (w_tick),
    .cargar      (w_cargar),
    .objetivo    (x_objetivo),
    .actual      (x_actual),
    .paso        (paso_x),
    .dir         (dir_x),
    .en_objetivo (w_en_x)
  );

  eje_paso #(
    .bits_eje (bits_eje)
  ) u_eje_y (
    .clock       (clock),
    .reset       (reset),
    .tick        (w_tick),
    .cargar      (w_cargar),
    .objetivo    (y_objetivo),
    .actual      (y_actual),
    .paso        (paso_y),
    .dir         (dir_y),
    .en_objetivo (w_en_y)
  );

  assign dato_siguiente = r_dato;
  assign en_movimiento  = r_en_mov;
  assign estado         = r_estado;

endmodule

// File: tb/tb_ejecutor_corte.sv
// Directed bench for ejecutor_corte with default parameters; outputs are
// sampled on the falling edge, inputs driven on the falling edge.
module tb_ejecutor_corte;

  localparam logic [2:0] ST_REPOSO = 3'd0;
  localparam logic [2:0] ST_CARGAR = 3'd1;
  localparam logic [2:0] ST_PEDIR  = 3'd4;

  logic       clock = 1'b0;
  logic       reset;
  logic       cortando;
  logic [5:0] x_objetivo;
  logic [5:0] y_objetivo;
  logic       dato_siguiente;
  logic [5:0] x_actual;
  logic [5:0] y_actual;
  logic       paso_x;
  logic       paso_y;
  logic       dir_x;
  logic       dir_y;
  logic       en_movimiento;
  logic [2:0] estado;

  always #5 clock = ~clock;

  ejecutor_corte #(
    .bits_eje            (6),
    .divisor_paso        (4),
    .latencia_dato       (2),
    .ciclos_asentamiento (3)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .cortando       (cortando),
    .x_objetivo     (x_objetivo),
    .y_objetivo     (y_objetivo),
    .dato_siguiente (dato_siguiente),
    .x_actual       (x_actual),
    .y_actual       (y_actual),
    .paso_x         (paso_x),
    .paso_y         (paso_y),
    .dir_x          (dir_x),
    .dir_y          (dir_y),
    .en_movimiento  (en_movimiento),
    .estado         (estado)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Observation record, cycle indices counted from the call (first sample = 1).
  int   n_px, n_py, err_dx, err_dy, gap_bad;
  int   c_px0, c_py0, c_plast_x, c_plast_y, c_plast, c_dato, c_mov;
  logic [2:0] st1;
  bit   expira;

  task automatic observar(input int budget, input logic dir_esp);
    n_px = 0; n_py = 0; err_dx = 0; err_dy = 0; gap_bad = 0;
    c_px0 = 0; c_py0 = 0; c_plast_x = 0; c_plast_y = 0; c_plast = 0;
    c_dato = 0; c_mov = 0; st1 = 3'bxxx; expira = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clock);
      if (k == 1) st1 = estado;
      if (en_movimiento === 1'b1 && c_mov == 0) c_mov = k;
      if (paso_x === 1'b1) begin
        if (n_px == 0) c_px0 = k;
        else if (k - c_plast_x != 4) gap_bad++;
        if (dir_x !== dir_esp) err_dx++;
        c_plast_x = k; c_plast = k; n_px++;
      end
      if (paso_y === 1'b1) begin
        if (n_py == 0) c_py0 = k;
        else if (k - c_plast_y != 4) gap_bad++;
        if (dir_y !== dir_esp) err_dy++;
        c_plast_y = k; c_plast = k; n_py++;
      end
      if (dato_siguiente === 1'b1) begin
        c_dato = k;
        return;
      end
    end
    expira = 1'b1;
  endtask

  initial begin
    bit hallado;

    // Reset held for two cycles
    reset = 1'b0; cortando = 1'b0; x_objetivo = '0; y_objetivo = '0;
    repeat (2) @(negedge clock);
    check("rst_estado", estado, ST_REPOSO);
    check("rst_x", x_actual, 0);
    check("rst_y", y_actual, 0);
    check("rst_paso_x", paso_x, 0);
    check("rst_paso_y", paso_y, 0);
    check("rst_dir_x", dir_x, 0);
    check("rst_dir_y", dir_y, 0);
    check("rst_dato", dato_siguiente, 0);
    check("rst_en_mov", en_movimiento, 0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_estado", estado, ST_REPOSO);

    // (0,0) -> (3,1)
    x_objetivo = 6'd3; y_objetivo = 6'd1; cortando = 1'b1;
    observar(40, 1'b1);
    check("s1_expira", expira, 0);
    check("s1_st1", st1, ST_CARGAR);
    check("s1_mov_start", c_mov, 3);
    check("s1_npx", n_px, 3);
    check("s1_npy", n_py, 1);
    check("s1_dirx", err_dx, 0);
    check("s1_diry", err_dy, 0);
    check("s1_px0", c_px0, 6);
    check("s1_py0", c_py0, 6);
    check("s1_gap", gap_bad, 0);
    check("s1_last", c_plast, 14);
    check("s1_dato", c_dato, 18);
    check("s1_x", x_actual, 3);
    check("s1_y", y_actual, 1);
    check("s1_estado", estado, ST_PEDIR);

    // (3,1) -> (0,0), next point presented during PEDIR
    x_objetivo = 6'd0; y_objetivo = 6'd0;
    observar(40, 1'b0);
    check("s2_st1", st1, ST_CARGAR);
    check("s2_npx", n_px, 3);
    check("s2_npy", n_py, 1);
    check("s2_dirx", err_dx, 0);
    check("s2_diry", err_dy, 0);
    check("s2_px0", c_px0, 6);
    check("s2_dato", c_dato, 18);
    check("s2_x", x_actual, 0);
    check("s2_y", y_actual, 0);

    // (0,0) -> (6,0), cortando dropped just before the tick while x = 2
    x_objetivo = 6'd6; y_objetivo = 6'd0;
    hallado = 1'b0;
    for (int k = 0; k < 40 && !hallado; k++) begin
      @(negedge clock);
      if (x_actual === 6'd2) hallado = 1'b1;
    end
    check("s3_reach2", hallado, 1);
    repeat (3) @(negedge clock);
    check("s3_x_pre", x_actual, 2);
    cortando = 1'b0;
    @(negedge clock);
    check("s3_estado", estado, ST_REPOSO);
    check("s3_paso", paso_x, 0);
    check("s3_en_mov", en_movimiento, 0);
    observar(30, 1'b1);
    check("s3_expira", expira, 1);
    check("s3_npx", n_px, 0);
    check("s3_dato", c_dato, 0);
    check("s3_x", x_actual, 2);

    // (2,0) -> (5,5)
    x_objetivo = 6'd5; y_objetivo = 6'd5; cortando = 1'b1;
    observar(60, 1'b1);
    check("s4_npx", n_px, 3);
    check("s4_npy", n_py, 5);
    check("s4_dirx", err_dx, 0);
    check("s4_diry", err_dy, 0);
    check("s4_gap", gap_bad, 0);
    check("s4_last", c_plast, 22);
    check("s4_dato", c_dato, 26);
    check("s4_x", x_actual, 5);
    check("s4_y", y_actual, 5);

    // (5,5) -> (5,5): zero steps
    observar(20, 1'b1);
    check("s5_npx", n_px, 0);
    check("s5_npy", n_py, 0);
    check("s5_mov", c_mov, 3);
    check("s5_dato", c_dato, 7);
    check("s5_x", x_actual, 5);
    cortando = 1'b0;

    // Full-range move (0,0) -> (63,63)
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    check("s6_x0", x_actual, 0);
    x_objetivo = 6'd63; y_objetivo = 6'd63; cortando = 1'b1;
    observar(300, 1'b1);
    check("s6_expira", expira, 0);
    check("s6_npx", n_px, 63);
    check("s6_npy", n_py, 63);
    check("s6_dirx", err_dx, 0);
    check("s6_gap", gap_bad, 0);
    check("s6_dato", c_dato, 258);
    check("s6_x", x_actual, 63);
    check("s6_y", y_actual, 63);
    cortando = 1'b0;

    // Reset during MOVER
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1; cortando = 1'b1;
    hallado = 1'b0;
    for (int k = 0; k < 100 && !hallado; k++) begin
      @(negedge clock);
      if (x_actual === 6'd10) hallado = 1'b1;
    end
    check("s7_reach10", hallado, 1);
    reset = 1'b0;
    @(negedge clock);
    check("s7_x", x_actual, 0);
    check("s7_y", y_actual, 0);
    check("s7_estado", estado, ST_REPOSO);
    check("s7_en_mov", en_movimiento, 0);
    check("s7_paso", paso_x, 0);
    reset = 1'b1; cortando = 1'b0;
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
